// File: rtl/division_sat_if.sv
// Handshake and data bundle for division_sat.
// zflag is present only when DIVISION_SAT_ZFLAG_EN is defined.
interface division_sat_if #(
    parameter int size = 21
);
    logic                   start;
    logic signed [size-1:0] A;
    logic signed [size-1:0] B;
    logic signed [size-1:0] Div;
    logic                   done;
    logic                   busy;
`ifdef DIVISION_SAT_ZFLAG_EN
    logic                   zflag;

    modport master (output start, A, B, input Div, done, busy, zflag);
    modport slave  (input start, A, B, output Div, done, busy, zflag);
`else
    modport master (output start, A, B, input Div, done, busy);
    modport slave  (input start, A, B, output Div, done, busy);
`endif
endinterface

// File: rtl/division_sat.sv
// Signed fixed-point restoring divider (Q format, pf fractional bits) with saturation.
// Optional divide-by-zero flag output enabled by macro DIVISION_SAT_ZFLAG_EN.
module division_sat #(
    parameter int size = 21,
    parameter int pf   = 15
) (
    input  logic          clk,
    input  logic          rst_n,
    division_sat_if.slave bus
);
    // state | meaning
    // IDLE  | waiting for start (ignored during the done cycle)
    // CALC  | one restoring shift-subtract step per cycle, N cycles
    // FIX   | apply sign and saturation, register Div, pulse done
    localparam int N  = size + pf;
    localparam int CW = $clog2(N + 1);
    localparam logic [CW-1:0]   CNT_LOAD = CW'(N - 1);
    localparam logic [N-1:0]    MAX_MAG  = {{(pf + 1){1'b0}}, {(size - 1){1'b1}}};
    localparam logic [N-1:0]    MIN_MAG  = {{pf{1'b0}}, 1'b1, {(size - 1){1'b0}}};
    localparam logic [size-1:0] POS_SAT  = {1'b0, {(size - 1){1'b1}}};
    localparam logic [size-1:0] NEG_SAT  = {1'b1, {(size - 1){1'b0}}};

    typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

    state_t          r_state;
    state_t          w_next;
    logic [N-1:0]    r_dvd;
    logic [size-1:0] r_rem;
    logic [size-1:0] r_bmag;
    logic [CW-1:0]   r_cnt;
    logic            r_sign;
    logic            r_azero;
    logic [size-1:0] r_div;
    logic            r_done;
    logic            r_busy;

    logic [size-1:0] w_a_raw;
    logic [size-1:0] w_b_raw;
    logic [size-1:0] w_amag;
    logic [size-1:0] w_bmag;
    logic [size:0]   w_rem_sh;
    logic [size:0]   w_diff;
    logic            w_ge;
    logic            w_accept;
    logic [size-1:0] w_result;

    assign w_a_raw  = bus.A;
    assign w_b_raw  = bus.B;
    // Magnitudes are unsigned so that -2^(size-1) maps to 2^(size-1) exactly.
    assign w_amag   = w_a_raw[size-1] ? -w_a_raw : w_a_raw;
    assign w_bmag   = w_b_raw[size-1] ? -w_b_raw : w_b_raw;
    assign w_accept = (r_state == IDLE) && bus.start && !r_done;

    // r_dvd shifts the dividend out at the top while quotient bits enter at the bottom.
    assign w_rem_sh = {r_rem, r_dvd[N-1]};
    assign w_diff   = w_rem_sh - {1'b0, r_bmag};
    assign w_ge     = (w_rem_sh >= {1'b0, r_bmag});

    always_ff @(posedge clk) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (w_accept) w_next = CALC;
            CALC:    if (r_cnt == '0) w_next = FIX;
            FIX:     w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // B = 0 yields an all-ones quotient, which saturates toward the sign of A.
    always_comb begin
        w_result = '0;
        if (r_azero)     w_result = '0;
        else if (r_sign) w_result = (r_dvd >= MIN_MAG) ? NEG_SAT : -r_dvd[size-1:0];
        else             w_result = (r_dvd > MAX_MAG)  ? POS_SAT : r_dvd[size-1:0];
    end

`ifdef DIVISION_SAT_ZFLAG_EN
    logic r_bzero;
    logic r_zflag;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_bzero <= 1'b0;
            r_zflag <= 1'b0;
        end else if (w_accept) begin
            r_bzero <= (w_b_raw == '0);
        end else if (r_state == FIX) begin
            r_zflag <= r_bzero;
        end
    end

    assign bus.zflag = r_zflag;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_dvd   <= '0;
            r_rem   <= '0;
            r_bmag  <= '0;
            r_cnt   <= '0;
            r_sign  <= 1'b0;
            r_azero <= 1'b0;
            r_div   <= '0;
            r_done  <= 1'b0;
            r_busy  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_dvd   <= {w_amag, {pf{1'b0}}};
                        r_rem   <= '0;
                        r_bmag  <= w_bmag;
                        r_sign  <= w_a_raw[size-1] ^ w_b_raw[size-1];
                        r_azero <= (w_a_raw == '0);
                        r_cnt   <= CNT_LOAD;
                        r_busy  <= 1'b1;
                    end
                end
                CALC: begin
                    r_dvd <= {r_dvd[N-2:0], w_ge};
                    r_rem <= size'(w_ge ? w_diff : w_rem_sh);
                    r_cnt <= r_cnt - CW'(1);
                end
                FIX: begin
                    r_div  <= w_result;
                    r_done <= 1'b1;
                    r_busy <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    assign bus.Div  = r_div;
    assign bus.done = r_done;
    assign bus.busy = r_busy;
endmodule

// File: doc/division_sat.md
DIVISION_SAT -- requirements
Module: division_sat

Interface
REQ-001 The block SHALL have parameter size, default 21, meaning total word width in bits, two's complement.
REQ-002 The block SHALL have parameter pf, default 15, meaning the number of fractional bits; the integer part is size-1-pf bits plus sign.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst_n, input, 1 bit: synchronous reset, active-low, sampled on the rising edge of clk.
REQ-005 The block SHALL have port start, input, 1 bit: request to begin a division; sampled only in IDLE.
REQ-006 The block SHALL have port A, input, size bits, signed: the dividend.
REQ-007 The block SHALL have port B, input, size bits, signed: the divisor.
REQ-008 The block SHALL have port Div, output, size bits, signed: the registered quotient A/B in the same Q format.
REQ-009 The block SHALL have port done, output, 1 bit: a one-cycle pulse marking Div as newly valid.
REQ-010 The block SHALL have port busy, output, 1 bit: high from the cycle after start is accepted until done is asserted.

Function
REQ-011 The block SHALL use the states IDLE, CALC and FIX, with N = size+pf iterations in CALC (default 36).
REQ-012 In IDLE, start=1 SHALL latch A and B, latch the result sign A[size-1]^B[size-1], load |A|<<pf and |B| as unsigned values, and move to CALC.
REQ-013 |A| SHALL be size bits unsigned so that A = -2^(size-1) is represented exactly.
REQ-014 CALC SHALL perform one restoring shift-subtract step per cycle, producing one quotient bit MSB-first, and SHALL move to FIX after N cycles.
REQ-015 FIX SHALL apply the sign and the saturation rules, register Div, pulse done for one cycle, and return to IDLE.
REQ-016 done SHALL rise exactly N+2 cycles after the cycle in which start was sampled high (default 38); busy SHALL fall in the same cycle.
REQ-017 The quotient SHALL truncate toward zero (magnitude truncation before sign application).
REQ-018 For a positive result with magnitude > 2^(size-1)-1, Div SHALL equal {1'b0,{(size-1){1'b1}}}.
REQ-019 For a negative result with magnitude > 2^(size-1), Div SHALL equal {1'b1,{(size-1){1'b0}}}.
REQ-020 For B=0 and A>0, Div SHALL be maximum positive; for B=0 and A<0, maximum negative; for B=0 and A=0, zero. Latency is unchanged in all three cases.
REQ-021 For A=0 with B≠0, Div SHALL be 0.
REQ-022 start while busy SHALL be ignored, and changes on A and B while busy SHALL NOT affect the result.
REQ-023 Div SHALL hold its last value until the next done.
REQ-024 start asserted in the same cycle that done pulses SHALL be ignored; a new operation is accepted in the following IDLE cycle.

Reset
REQ-025 With rst_n=0 at a clock edge, the state SHALL go to IDLE and Div, done, busy (and zflag) SHALL all be 0, including mid-CALC or mid-FIX.
REQ-026 An operation interrupted by reset SHALL produce no done, and the first start after reset release SHALL complete normally.

Configuration
REQ-027 With the macro DIVISION_SAT_ZFLAG_EN defined, output port zflag (1 bit) SHALL exist, updated with Div: 1 when the latched B was 0, else 0.
REQ-028 Without DIVISION_SAT_ZFLAG_EN, zflag SHALL be absent, and all other behaviour, including REQ-020, SHALL be identical.

Verification
REQ-029 Basic divide: A=0x18000 (3.0), B=0x0C000 (1.5), start pulse -> done 38 cycles later, Div=0x10000 (2.0), busy high for the intervening cycles.
REQ-030 Signed and truncation cases SHALL be covered:
- A=0x1F8000 (-1.0), B=0x20000 (4.0) -> Div=0x1FE000 (-0.25).
- A=0x08000, B=0x18000 -> Div=0x02AAA.
- A=0x1F8000, B=0x18000 -> Div=0x1FD556.
REQ-031 Saturation: A=0x0F0000 (30.0), B=0x04000 (0.5) -> Div=0x0FFFFF; A=0x0F0000, B=0x1FC000 (-0.5) -> Div=0x100000.
REQ-032 Divide by zero: A=0x1F0000 (-2.0), B=0 -> Div=0x100000, zflag=1 (macro defined); A=0, B=0 -> Div=0.
REQ-033 Control boundaries SHALL be covered:
- A second start 5 cycles into an operation, with A and B changed -> ignored, first result unaffected.
- rst_n low at cycle 10 of CALC -> Div=0, busy=0, no done; the next start yields the correct result.
